// File: rtl/map_ram_arbiter.sv
// Single-port map/sprite RAM arbiter: video reads plus two tank engines, one op per
// cycle, with a tag pipeline that steers read data back to whoever issued the read.
module map_ram_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  vid_req,
  input  logic [ADDR_W-1:0]     vid_addr,
  output logic                  vid_gnt,
  output logic                  vid_rvalid,
  output logic [DATA_W-1:0]     vid_rdata,
  input  logic [1:0]            t_req,
  input  logic [1:0]            t_we,
  input  logic [2*ADDR_W-1:0]   t_addr,
  input  logic [2*DATA_W-1:0]   t_wdata,
  output logic [1:0]            t_gnt,
  output logic [1:0]            t_rvalid,
  output logic [DATA_W-1:0]     t_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    SRC_VID = 2'd0,
    SRC_T0  = 2'd1,
    SRC_T1  = 2'd2
  } src_e;

  typedef struct packed {
    logic valid;
    src_e src;
  } tag_t;

  logic              rr_q, rr_d;
  logic [CNT_W-1:0]  starveCnt_q, starveCnt_d;
  logic              ramEn_q, ramEn_d;
  logic              ramWe_q, ramWe_d;
  logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
  logic [DATA_W-1:0] ramWdata_q, ramWdata_d;
  tag_t [RD_LAT:0]   tag_q;
  tag_t              newTag;
  logic [DATA_W-1:0] vidData_q, tData_q;

  logic              anyTReq;
  logic              tankStarved;
  logic              vidGnt;
  logic [1:0]        tGnt;
  logic              tankGnt;
  logic              tankIdx;
  logic [ADDR_W-1:0] tAddrSel;
  logic [DATA_W-1:0] tWdataSel;
  logic              tWeSel;
  tag_t              retTag;
  logic              vidRvalid;
  logic [1:0]        tRvalid;

  // Video wins unless a tank has already sat through STARVE_MAX video grants.
  // Grants are masked while reset is asserted so every output reads 0 at once.
  always_comb begin
    anyTReq     = |t_req;
    tankStarved = anyTReq && (starveCnt_q == STARVE_LIM);
    vidGnt      = reset_reset_n && vid_req && !tankStarved;
    tGnt        = 2'b00;
    if (reset_reset_n && !vidGnt) begin
      if (t_req == 2'b11) begin
        tGnt = rr_q ? 2'b10 : 2'b01;
      end else begin
        tGnt = t_req;
      end
    end
    tankGnt = |tGnt;
    tankIdx = tGnt[1];
  end

  always_comb begin
    tAddrSel  = tankIdx ? t_addr[2*ADDR_W-1:ADDR_W]   : t_addr[ADDR_W-1:0];
    tWdataSel = tankIdx ? t_wdata[2*DATA_W-1:DATA_W]  : t_wdata[DATA_W-1:0];
    tWeSel    = tankIdx ? t_we[1] : t_we[0];
  end

  always_comb begin
    rr_d = rr_q;
    if (tankGnt) begin
      rr_d = ~tankIdx;
    end

    starveCnt_d = starveCnt_q;
    if (tankGnt || !anyTReq) begin
      starveCnt_d = '0;
    end else if (vidGnt && (starveCnt_q != STARVE_LIM)) begin
      starveCnt_d = starveCnt_q + 1'b1;
    end

    ramEn_d    = vidGnt || tankGnt;
    ramWe_d    = tankGnt && tWeSel;
    ramAddr_d  = ramAddr_q;
    ramWdata_d = ramWdata_q;
    if (vidGnt) begin
      ramAddr_d = vid_addr;
    end else if (tankGnt) begin
      ramAddr_d  = tAddrSel;
      ramWdata_d = tWdataSel;
    end

    // Writes still enter the pipeline, as invalid tags, to keep slots aligned.
    newTag.valid = vidGnt || (tankGnt && !tWeSel);
    newTag.src   = vidGnt ? SRC_VID : (tankIdx ? SRC_T1 : SRC_T0);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rr_q        <= 1'b0;
      starveCnt_q <= '0;
      ramEn_q     <= 1'b0;
      ramWe_q     <= 1'b0;
      ramAddr_q   <= '0;
      ramWdata_q  <= '0;
      tag_q       <= '0;
      vidData_q   <= '0;
      tData_q     <= '0;
    end else begin
      rr_q        <= rr_d;
      starveCnt_q <= starveCnt_d;
      ramEn_q     <= ramEn_d;
      ramWe_q     <= ramWe_d;
      ramAddr_q   <= ramAddr_d;
      ramWdata_q  <= ramWdata_d;
      tag_q       <= {tag_q[RD_LAT-1:0], newTag};
      if (vidRvalid) begin
        vidData_q <= ram_rdata;
      end
      if (|tRvalid) begin
        tData_q <= ram_rdata;
      end
    end
  end

  // The oldest tag lines up with the cycle the RAM presents data for its op.
  always_comb begin
    retTag      = tag_q[RD_LAT];
    vidRvalid   = retTag.valid && (retTag.src == SRC_VID);
    tRvalid[0]  = retTag.valid && (retTag.src == SRC_T0);
    tRvalid[1]  = retTag.valid && (retTag.src == SRC_T1);
  end

  assign vid_gnt    = vidGnt;
  assign t_gnt      = tGnt;
  assign vid_rvalid = vidRvalid;
  assign t_rvalid   = tRvalid;
  assign vid_rdata  = vidRvalid ? ram_rdata : vidData_q;
  assign t_rdata    = (|tRvalid) ? ram_rdata : tData_q;
  assign ram_en     = ramEn_q;
  assign ram_we     = ramWe_q;
  assign ram_addr   = ramAddr_q;
  assign ram_wdata  = ramWdata_q;

endmodule

// File: tb/tb_map_ram_arbiter.sv
// Bench for map_ram_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a queue-based reference model and a simple RAM model.
module tb_map_ram_arbiter;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 16;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 8;

  logic                clk_clk;
  logic                reset_reset_n;
  logic                vid_req;
  logic [ADDR_W-1:0]   vid_addr;
  logic                vid_gnt;
  logic                vid_rvalid;
  logic [DATA_W-1:0]   vid_rdata;
  logic [1:0]          t_req;
  logic [1:0]          t_we;
  logic [2*ADDR_W-1:0] t_addr;
  logic [2*DATA_W-1:0] t_wdata;
  logic [1:0]          t_gnt;
  logic [1:0]          t_rvalid;
  logic [DATA_W-1:0]   t_rdata;
  logic                ram_en;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;

  map_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .t_req(t_req), .t_we(t_we), .t_addr(t_addr), .t_wdata(t_wdata),
    .t_gnt(t_gnt), .t_rvalid(t_rvalid), .t_rdata(t_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int                due;
    int                src;
    logic [ADDR_W-1:0] addr;
  } ret_t;

  ret_t              retQ[$];
  int                starveCnt;
  bit                favourT1;
  logic              expEn, expWe;
  logic [ADDR_W-1:0] expAddr;
  logic [DATA_W-1:0] expWdata, expVidData, expTData;
  bit                mGntVid;
  bit [1:0]          mGntT;
  bit                issRd[64];
  logic [ADDR_W-1:0] issAddr[64];

  int                g;
  bit                anyT;
  bit                vv;
  logic [1:0]        tv;
  logic [DATA_W-1:0] d;
  logic [ADDR_W-1:0] a;

  function automatic logic [DATA_W-1:0] ramFn(input logic [ADDR_W-1:0] addr);
    return DATA_W'(addr) ^ 16'hA5A5;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic vReq, input logic [ADDR_W-1:0] vAddr,
                               input logic [1:0] tReq, input logic [1:0] tWe,
                               input logic [2*ADDR_W-1:0] tAddr,
                               input logic [2*DATA_W-1:0] tWdata);
    vid_req  = vReq;
    vid_addr = vAddr;
    t_req    = tReq;
    t_we     = tWe;
    t_addr   = tAddr;
    t_wdata  = tWdata;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 2'b00, 2'b00, '0, '0);
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_clk);
    #1;
  endtask

  // Requesters hold until granted, then may present a fresh random request.
  task automatic randomStep(input int pVid, input int pT);
    if (!vid_req || mGntVid) begin
      vid_req  = ($urandom_range(0, 99) < pVid);
      vid_addr = ADDR_W'($urandom);
    end
    for (int i = 0; i < 2; i++) begin
      if (!t_req[i] || mGntT[i]) begin
        t_req[i] = ($urandom_range(0, 99) < pT);
        t_we[i]  = 1'($urandom_range(0, 1));
        t_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'($urandom);
        t_wdata[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
    end
  endtask

  always @(posedge clk_clk) cyc <= cyc + 1;

  // RAM model: returns f(addr) RD_LAT cycles after each read the DUT actually issued.
  always @(posedge clk_clk) begin
    #1;
    if (cyc >= RD_LAT && issRd[(cyc - RD_LAT) % 64]) begin
      ram_rdata <= ramFn(issAddr[(cyc - RD_LAT) % 64]);
    end else begin
      ram_rdata <= DATA_W'($urandom);
    end
  end

  // Reference model: decides the winner from the arbitration rules, then expects
  // the RAM op one cycle later and the read return 1+RD_LAT cycles later.
  always @(negedge clk_clk) begin
    issRd[cyc % 64]   = reset_reset_n && ram_en && !ram_we;
    issAddr[cyc % 64] = ram_addr;
    if (!reset_reset_n) begin
      checkOutput("reset_ctrl", 64'({vid_gnt, t_gnt, vid_rvalid, t_rvalid, ram_en, ram_we}), 64'(0));
      checkOutput("reset_ram", 64'({ram_addr, ram_wdata}), 64'(0));
      checkOutput("reset_rdata", 64'({vid_rdata, t_rdata}), 64'(0));
      starveCnt  = 0;
      favourT1   = 1'b0;
      retQ.delete();
      expEn      = 1'b0;
      expWe      = 1'b0;
      expAddr    = '0;
      expWdata   = '0;
      expVidData = '0;
      expTData   = '0;
      mGntVid    = 1'b0;
      mGntT      = 2'b00;
    end else begin
      anyT = |t_req;
      if (vid_req && !(anyT && starveCnt >= STARVE_MAX)) g = 1;
      else if (t_req == 2'b11) g = favourT1 ? 3 : 2;
      else if (t_req[0]) g = 2;
      else if (t_req[1]) g = 3;
      else g = 0;

      checkOutput("vid_gnt", 64'(vid_gnt), 64'(g == 1));
      checkOutput("t_gnt", 64'(t_gnt), 64'({g == 3, g == 2}));
      checkOutput("ram_en", 64'(ram_en), 64'(expEn));
      checkOutput("ram_we", 64'(ram_we), 64'(expWe));
      checkOutput("ram_addr", 64'(ram_addr), 64'(expAddr));
      checkOutput("ram_wdata", 64'(ram_wdata), 64'(expWdata));

      vv = 1'b0;
      tv = 2'b00;
      if (retQ.size() > 0 && retQ[0].due == cyc) begin
        d = ramFn(retQ[0].addr);
        if (retQ[0].src == 1) begin
          vv = 1'b1;
          expVidData = d;
        end else begin
          tv = (retQ[0].src == 2) ? 2'b01 : 2'b10;
          expTData = d;
        end
        void'(retQ.pop_front());
      end
      checkOutput("vid_rvalid", 64'(vid_rvalid), 64'(vv));
      checkOutput("t_rvalid", 64'(t_rvalid), 64'(tv));
      checkOutput("vid_rdata", 64'(vid_rdata), 64'(expVidData));
      checkOutput("t_rdata", 64'(t_rdata), 64'(expTData));

      expEn = (g != 0);
      expWe = (g >= 2) && t_we[g-2];
      if (g == 1) begin
        a = vid_addr;
        expAddr = a;
      end else if (g >= 2) begin
        a = t_addr[(g-2)*ADDR_W +: ADDR_W];
        expAddr  = a;
        expWdata = t_wdata[(g-2)*DATA_W +: DATA_W];
      end
      if (g == 1 || (g >= 2 && !t_we[g-2])) begin
        retQ.push_back('{cyc + 1 + RD_LAT, g, a});
      end
      if (g >= 2 || !anyT) starveCnt = 0;
      else if (g == 1 && starveCnt < STARVE_MAX) starveCnt++;
      if (g == 2) favourT1 = 1'b1;
      if (g == 3) favourT1 = 1'b0;
      mGntVid = (g == 1);
      mGntT   = {g == 3, g == 2};
    end
  end

  initial begin
    ram_rdata = '0;
    foreach (issRd[i]) issRd[i] = 1'b0;
    idle();
    reset_reset_n = 1'b1;
    #2;
    reset_reset_n = 1'b0;
    repeat (3) tick();
    reset_reset_n = 1'b1;

    // Both engines reading for six cycles alternate starting from engine 0.
    tick();
    applyStimulus(1'b0, '0, 2'b11, 2'b00, {12'h222, 12'h111}, '0);
    for (int i = 0; i < 6; i++) begin
      sample();
      checkOutput("rr_alternate", 64'(t_gnt), 64'((i % 2) ? 2'b10 : 2'b01));
      tick();
    end
    idle();
    repeat (4) tick();

    // Single engine-0 read of 0x010 returns 0x010^0xA5A5 three cycles after grant.
    applyStimulus(1'b0, '0, 2'b01, 2'b00, {12'h000, 12'h010}, '0);
    sample();
    checkOutput("read_gnt", 64'(t_gnt), 64'(2'b01));
    tick();
    idle();
    sample();
    checkOutput("read_ram_en", 64'(ram_en), 64'(1));
    checkOutput("read_ram_addr", 64'(ram_addr), 64'(12'h010));
    tick();
    tick();
    sample();
    checkOutput("read_rvalid", 64'(t_rvalid), 64'(2'b01));
    checkOutput("read_rdata", 64'(t_rdata), 64'(16'hA5B5));
    repeat (2) tick();

    // Video outranks engine 1 until it stops requesting.
    applyStimulus(1'b1, 12'h0AB, 2'b10, 2'b00, {12'h155, 12'h000}, '0);
    for (int i = 0; i < 3; i++) begin
      sample();
      checkOutput("vid_priority", 64'(vid_gnt), 64'(1));
      tick();
    end
    vid_req = 1'b0;
    sample();
    checkOutput("tank_after_vid", 64'(t_gnt), 64'(2'b10));
    tick();
    idle();
    repeat (2) tick();

    // Engine-1 write: registered RAM op, no read return.
    applyStimulus(1'b0, '0, 2'b10, 2'b10, {12'h3FF, 12'h000}, {16'h1234, 16'h0000});
    sample();
    checkOutput("write_gnt", 64'(t_gnt), 64'(2'b10));
    tick();
    idle();
    sample();
    checkOutput("write_en_we", 64'({ram_en, ram_we}), 64'(2'b11));
    checkOutput("write_addr", 64'(ram_addr), 64'(12'h3FF));
    checkOutput("write_wdata", 64'(ram_wdata), 64'(16'h1234));
    for (int i = 0; i < 4; i++) begin
      tick();
      sample();
      checkOutput("write_no_rvalid", 64'(t_rvalid), 64'(0));
    end
    tick();

    // Video held 20 cycles against a waiting engine 0: tank slips in every 9th.
    applyStimulus(1'b1, 12'h020, 2'b01, 2'b00, {12'h000, 12'h030}, '0);
    for (int i = 0; i < 20; i++) begin
      sample();
      checkOutput("starve_vid_gnt", 64'(vid_gnt), 64'((i == 8 || i == 17) ? 0 : 1));
      checkOutput("starve_t_gnt", 64'(t_gnt), 64'((i == 8 || i == 17) ? 2'b01 : 2'b00));
      tick();
    end
    idle();
    repeat (3) tick();

    // Reset with two reads in flight: nothing comes back, arbitration restarts at engine 0.
    applyStimulus(1'b0, '0, 2'b11, 2'b00, {12'h066, 12'h055}, '0);
    tick();
    tick();
    reset_reset_n = 1'b0;
    sample();
    checkOutput("rst_gnt_zero", 64'({vid_gnt, t_gnt}), 64'(0));
    checkOutput("rst_ram_en_zero", 64'(ram_en), 64'(0));
    tick();
    reset_reset_n = 1'b1;
    sample();
    checkOutput("rst_rr_engine0", 64'(t_gnt), 64'(2'b01));
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      sample();
      checkOutput("rst_no_rvalid", 64'({vid_rvalid, t_rvalid}), 64'(0));
      tick();
    end
    repeat (6) tick();

    // Random traffic across several load mixes, with occasional resets.
    for (int phase = 0; phase < 4; phase++) begin
      int pVid;
      int pT;
      case (phase)
        0:       begin pVid = 30;  pT = 50; end
        1:       begin pVid = 95;  pT = 70; end
        2:       begin pVid = 60;  pT = 90; end
        default: begin pVid = 100; pT = 30; end
      endcase
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 249) == 0) begin
          reset_reset_n = 1'b0;
          tick();
          reset_reset_n = 1'b1;
        end
        randomStep(pVid, pT);
        tick();
      end
    end
    idle();
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
